// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port RAM (1 access/cycle, 1-cycle
// registered read) among NREQ requesters. Round-robin arbitration with
// optional locked bursts, registered RAM command, tagged read responses.
// Build option: define RAM_ARB_FIXED_PRI_EN for lowest-index-first priority
// in the ARB state instead of round-robin.
module sram_port_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned IW       = $clog2(NREQ),
  localparam int unsigned CW       = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_d,
  input  logic [WIDTH-1:0]      ram_q
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic             ram_we_q, ram_we_d;
  logic [WIDTH-1:0] ram_d_q, ram_d_d;
  logic             rd1_vld_q, rd1_vld_d, rd2_vld_q, rd2_vld_d;
  logic [IW-1:0]    rd1_id_q, rd1_id_d, rd2_id_q, rd2_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
`ifndef RAM_ARB_FIXED_PRI_EN
  int unsigned      rr_idx;
`endif

  // Successor index with wrap NREQ-1 -> 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : i + IW'(1);
  endfunction

  // Grant selection: owner only while locked, otherwise priority search.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifndef RAM_ARB_FIXED_PRI_EN
    rr_idx  = 0;
`endif
    if (!rst) begin
      if (state_q == ST_LOCK) begin
        gnt_vld = req_valid[owner_q];
        gnt_idx = owner_q;
      end else begin
`ifdef RAM_ARB_FIXED_PRI_EN
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (!gnt_vld && req_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(k);
          end
        end
`else
        for (int unsigned k = 0; k < NREQ; k++) begin
          rr_idx = 32'(ptr_q) + k;
          if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
          if (!gnt_vld && req_valid[rr_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(rr_idx);
          end
        end
`endif
      end
    end
  end

  // One-hot ready for the selected requester.
  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Next state: lock tracking, RAM command capture and read-tag pipeline.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    count_d     = count_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_d_d     = ram_d_q;
    rd1_vld_d   = 1'b0;
    rd1_id_d    = rd1_id_q;
    rd2_vld_d   = rd1_vld_q;
    rd2_id_d    = rd1_id_q;
    rsp_valid_d = rd2_vld_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    if (rd2_vld_q) begin
      rsp_id_d   = rd2_id_q;
      rsp_data_d = ram_q;
    end

    if (gnt_vld) begin
      ram_addr_d = req_addr[32'(gnt_idx)*AW +: AW];
      ram_we_d   = req_we[gnt_idx];
      ram_d_d    = req_wdata[32'(gnt_idx)*WIDTH +: WIDTH];
      rd1_vld_d  = !req_we[gnt_idx];
      rd1_id_d   = gnt_idx;
    end

    case (state_q)
      ST_ARB: begin
        if (gnt_vld) begin
          ptr_d = next_idx(gnt_idx);
          if (MAX_BURST > 1 && req_lock[gnt_idx]) begin
            state_d = ST_LOCK;
            owner_d = gnt_idx;
            count_d = CW'(1);
          end
        end
      end
      ST_LOCK: begin
        if (!req_valid[owner_q]) begin
          // Owner went idle: release at once, port idles this cycle.
          state_d = ST_ARB;
          ptr_d   = next_idx(owner_q);
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
          if (!req_lock[owner_q] || count_d == CW'(MAX_BURST)) begin
            state_d = ST_ARB;
            ptr_d   = next_idx(owner_q);
            count_d = '0;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State and output registers with synchronous reset; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      count_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_d_q     <= '0;
      rd1_vld_q   <= 1'b0;
      rd1_id_q    <= '0;
      rd2_vld_q   <= 1'b0;
      rd2_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      count_q     <= count_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_d_q     <= ram_d_d;
      rd1_vld_q   <= rd1_vld_d;
      rd1_id_q    <= rd1_id_d;
      rd2_vld_q   <= rd2_vld_d;
      rd2_id_q    <= rd2_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_d     = ram_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural single-port RAM.
// Honours RAM_ARB_FIXED_PRI_EN for the two-requester priority scenario.
module tb_sram_port_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned WIDTH     = 512;
  localparam int unsigned DEPTH     = 4096;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned AW        = 12;
  localparam int unsigned IW        = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [AW-1:0]         ram_addr;
  logic                  ram_we;
  logic [WIDTH-1:0]      ram_d;
  logic [WIDTH-1:0]      ram_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
  );

  // Single-port RAM, registered read returning the pre-write contents.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  function automatic logic [WIDTH-1:0] pat(input int unsigned a);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ a;
    return {16{w}};
  endfunction

  initial begin
    for (int i = 100; i < 104; i++) mem[i] <= pat(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic lock,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_lock[i]  = lock;
    req_addr[i*AW +: AW]       = a;
    req_wdata[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_we = '0;
    req_lock = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset_ready c=%0d got=%b exp=0000", c, req_ready);
      end
      n_checks++;
      if (ram_we !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_ram_we c=%0d got=%b exp=0", c, ram_we);
      end
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_rsp_valid c=%0d got=%b exp=0", c, rsp_valid);
      end
    end
    n_checks++;
    if (rsp_id !== 2'd0 || ram_addr !== 12'd0 || rsp_data !== '0 || ram_d !== '0) begin
      n_errors++;
      $display("FAIL reset_regs got id=%0d addr=%0d data_nz=%b d_nz=%b exp all zero",
               rsp_id, ram_addr, |rsp_data, |ram_d);
    end
    rst = 1'b0;
    clear_reqs();
  endtask

  task automatic test_rr_fairness();
    logic [NREQ-1:0] exp_rdy;
    int r;
    for (int c = 0; c < 11; c++) begin
      tick();
      clear_reqs();
      if (c < 8) for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, AW'(100 + i), '0);
      #1;
      if (c < 8) begin
        exp_rdy = '0;
        exp_rdy[c % 4] = 1'b1;
        n_checks++;
        if (req_ready !== exp_rdy) begin
          n_errors++;
          $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
        end
      end
      if (c >= 3) begin
        r = (c - 3) % 4;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IW'(r) || rsp_data !== pat(100 + r)) begin
          n_errors++;
          $display("FAIL rr_rsp c=%0d got v=%b id=%0d data_ok=%b exp v=1 id=%0d data_ok=1",
                   c, rsp_valid, rsp_id, rsp_data === pat(100 + r), r);
        end
      end else begin
        n_checks++;
        if (rsp_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL rr_rsp_early c=%0d got=%b exp=0", c, rsp_valid);
        end
      end
    end
    clear_reqs();
  endtask

  task automatic test_write_read();
    // cycle n: req1 writes 0xA5 to addr 10
    tick(); clear_reqs(); set_req(1, 1'b1, 1'b0, 12'd10, WIDTH'(8'hA5)); #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL wr_grant got=%b exp=0010", req_ready);
    end
    // n+1: req2 reads addr 10; write command visible on RAM port
    tick(); clear_reqs(); set_req(2, 1'b0, 1'b0, 12'd10, '0); #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_errors++; $display("FAIL rd_grant got=%b exp=0100", req_ready);
    end
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 12'd10 || ram_d !== WIDTH'(8'hA5)) begin
      n_errors++;
      $display("FAIL wr_cmd got we=%b addr=%0d d=%0h exp we=1 addr=10 d=a5",
               ram_we, ram_addr, ram_d[31:0]);
    end
    // n+2: read command on the port
    tick(); clear_reqs(); #1;
    n_checks++;
    if (ram_we !== 1'b0 || ram_addr !== 12'd10 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_cmd got we=%b addr=%0d v=%b exp we=0 addr=10 v=0",
               ram_we, ram_addr, rsp_valid);
    end
    // n+3: idle cycle holds the address and data
    tick(); #1;
    n_checks++;
    if (ram_we !== 1'b0 || ram_addr !== 12'd10 || ram_d !== '0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_hold got we=%b addr=%0d d=%0h v=%b exp we=0 addr=10 d=0 v=0",
               ram_we, ram_addr, ram_d[31:0], rsp_valid);
    end
    // n+4: response carries the new data
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== WIDTH'(8'hA5)) begin
      n_errors++;
      $display("FAIL wr_rd_rsp got v=%b id=%0d data=%0h exp v=1 id=2 data=a5",
               rsp_valid, rsp_id, rsp_data[31:0]);
    end
    // m: req2 reads addr 10, m+1: req1 writes 0x3C there
    tick(); clear_reqs(); set_req(2, 1'b0, 1'b0, 12'd10, '0); #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_errors++; $display("FAIL rd2_grant got=%b exp=0100", req_ready);
    end
    tick(); clear_reqs(); set_req(1, 1'b1, 1'b0, 12'd10, WIDTH'(8'h3C)); #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL wr2_grant got=%b exp=0010", req_ready);
    end
    tick(); clear_reqs(); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL rd_wr_early got=%b exp=0", rsp_valid);
    end
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== WIDTH'(8'hA5)) begin
      n_errors++;
      $display("FAIL rd_wr_rsp got v=%b id=%0d data=%0h exp v=1 id=2 data=a5",
               rsp_valid, rsp_id, rsp_data[31:0]);
    end
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL rsp_pulse got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_lock_burst();
    int exp_g [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [NREQ-1:0] exp_rdy;
    for (int c = 0; c < 12; c++) begin
      tick(); clear_reqs();
      set_req(0, 1'b1, 1'b1, 12'd200, pat(0));
      set_req(1, 1'b1, 1'b0, 12'd201, pat(1));
      #1;
      exp_rdy = '0;
      exp_rdy[exp_g[c]] = 1'b1;
      n_checks++;
      if (req_ready !== exp_rdy || rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL lock_burst c=%0d got rdy=%b v=%b exp rdy=%b v=0",
                 c, req_ready, rsp_valid, exp_rdy);
      end
    end
    tick(); clear_reqs(); #1;
    tick(); #1;
  endtask

  task automatic test_lock_idle_release();
    logic v0 [7] = '{1, 1, 0, 0, 1, 1, 0};
    logic l0 [7] = '{1, 1, 0, 0, 1, 0, 0};
    logic v3 [7] = '{0, 1, 1, 1, 1, 1, 1};
    logic [NREQ-1:0] exp_rdy [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000,
                                     4'b0001, 4'b0001, 4'b1000};
    for (int c = 0; c < 7; c++) begin
      tick(); clear_reqs();
      if (v0[c]) set_req(0, 1'b1, l0[c], 12'd300, pat(5));
      if (v3[c]) set_req(3, 1'b1, 1'b0, 12'd301, pat(6));
      #1;
      n_checks++;
      if (req_ready !== exp_rdy[c]) begin
        n_errors++;
        $display("FAIL lock_release c=%0d got=%b exp=%b", c, req_ready, exp_rdy[c]);
      end
    end
    tick(); clear_reqs(); #1;
  endtask

  task automatic test_reset_mid_read();
    tick(); clear_reqs(); set_req(0, 1'b0, 1'b0, 12'd100, '0); #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL rmr_grant0 got=%b exp=0001", req_ready);
    end
    tick(); clear_reqs(); set_req(2, 1'b0, 1'b0, 12'd101, '0); #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_errors++; $display("FAIL rmr_grant2 got=%b exp=0100", req_ready);
    end
    tick(); clear_reqs(); rst = 1'b1; req_valid = 4'b0101; #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_errors++; $display("FAIL rmr_ready_in_rst got=%b exp=0000", req_ready);
    end
    for (int c = 3; c < 6; c++) begin
      tick(); rst = 1'b0; clear_reqs(); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++; $display("FAIL rmr_rsp n+%0d got=%b exp=0", c, rsp_valid);
      end
      if (c == 3) begin
        n_checks++;
        if (rsp_id !== 2'd0 || ram_addr !== 12'd0 || ram_we !== 1'b0) begin
          n_errors++;
          $display("FAIL rmr_regs got id=%0d addr=%0d we=%b exp 0 0 0",
                   rsp_id, ram_addr, ram_we);
        end
      end
    end
  endtask

  task automatic test_two_requesters();
    logic [NREQ-1:0] exp_rdy;
    for (int c = 0; c < 6; c++) begin
      tick(); clear_reqs();
      set_req(1, 1'b1, 1'b0, 12'd400, pat(7));
      set_req(3, 1'b1, 1'b0, 12'd401, pat(8));
      #1;
`ifdef RAM_ARB_FIXED_PRI_EN
      exp_rdy = 4'b0010;
`else
      exp_rdy = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL two_req c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
      end
    end
    tick(); clear_reqs(); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_rr_fairness();
    test_write_read();
    test_lock_burst();
    test_lock_idle_release();
    test_reset_mid_read();
    test_two_requesters();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
